// File: rtl/program_memory_loader_pkg.sv
// Shared constants and state encoding for the program memory loader.
package program_memory_loader_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = BYTE_WIDTH * BYTES_PER_WORD;
  localparam int LANE_WIDTH     = 2;
  localparam int ASM_WIDTH      = (BYTES_PER_WORD - 1) * BYTE_WIDTH;

  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/program_memory_loader_ram.sv
// Instruction RAM: one synchronous write port for the loader and one
// asynchronous read port for the core's fetch stage.
module program_ram #(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 32,
  parameter     INIT_FILE = "",
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Loader writes land on the rising edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_memory_loader.sv
// Writable instruction memory fed by a byte-stream loader. Bytes are packed
// little-endian into words and written sequentially from word 0 while the
// core is held; the fetch port stays combinational throughout.
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter     INIT_FILE    = "",
  localparam int AW          = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Load_Start_i,
  input  logic                  Load_End_i,
  input  logic [BYTE_WIDTH-1:0] Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Byte_Ready_o,
  input  logic [DATA_WIDTH-1:0] Address_i,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic                  Core_Hold_o,
  output logic                  Load_Done_o,
  output logic [AW:0]           Word_Count_o,
  output logic                  Overflow_o
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(MEMORY_DEPTH);

  state_t                r_state;
  state_t                w_stateNext;
  logic [LANE_WIDTH-1:0] r_lane;
  logic [LANE_WIDTH-1:0] w_laneNext;
  logic [ASM_WIDTH-1:0]  r_asm;
  logic [ASM_WIDTH-1:0]  w_asmNext;
  logic [AW:0]           r_count;
  logic [AW:0]           w_countNext;
  logic                  r_overflow;
  logic                  w_overflowNext;

  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_unusedAddr;

  assign w_full   = (r_count == FULL_COUNT);
  assign w_accept = (r_state == ST_LOAD) && Byte_Valid_i;

  // Next-state, byte packing, word write and overflow decisions.
  always_comb begin
    w_stateNext    = r_state;
    w_laneNext     = r_lane;
    w_asmNext      = r_asm;
    w_countNext    = r_count;
    w_overflowNext = r_overflow;
    w_we           = 1'b0;
    w_waddr        = r_count[AW-1:0];
    w_wdata        = '0;

    case (r_state)
      ST_IDLE: begin
        if (Load_Start_i) begin
          w_stateNext    = ST_LOAD;
          w_laneNext     = '0;
          w_asmNext      = '0;
          w_countNext    = '0;
          w_overflowNext = 1'b0;
        end
      end

      ST_LOAD: begin
        if (w_accept) begin
          if (r_lane == LAST_LANE) begin
            if (w_full) begin
              w_overflowNext = 1'b1;
            end else begin
              w_we        = 1'b1;
              w_wdata     = DATA_WIDTH'({Byte_i, r_asm});
              w_countNext = r_count + (AW+1)'(1);
            end
            w_laneNext = '0;
            w_asmNext  = '0;
          end else begin
            case (r_lane)
              2'd0:    w_asmNext[7:0]   = Byte_i;
              2'd1:    w_asmNext[15:8]  = Byte_i;
              default: w_asmNext[23:16] = Byte_i;
            endcase
            w_laneNext = r_lane + LANE_WIDTH'(1);
          end
        end
        if (Load_End_i) begin
          w_stateNext = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (r_lane != '0) begin
          if (w_full) begin
            w_overflowNext = 1'b1;
          end else begin
            w_we        = 1'b1;
            w_wdata     = DATA_WIDTH'({{BYTE_WIDTH{1'b0}}, r_asm});
            w_countNext = r_count + (AW+1)'(1);
          end
        end
        w_laneNext  = '0;
        w_asmNext   = '0;
        w_stateNext = ST_IDLE;
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Loader state register; a reset abandons any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lane     <= '0;
      r_asm      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_lane     <= w_laneNext;
      r_asm      <= w_asmNext;
      r_count    <= w_countNext;
      r_overflow <= w_overflowNext;
    end
  end

  assign Byte_Ready_o = (r_state == ST_LOAD);
  assign Core_Hold_o  = (r_state != ST_IDLE);
  assign Load_Done_o  = (r_state == ST_FLUSH);
  assign Word_Count_o = r_count;
  assign Overflow_o   = r_overflow;

  // Fetch addresses wrap: only the word-index bits reach the RAM.
  assign w_unusedAddr = ^{Address_i[DATA_WIDTH-1:AW+2], Address_i[1:0]};

  program_ram #(
    .DEPTH     (MEMORY_DEPTH),
    .WIDTH     (DATA_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we & ~reset),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (Address_i[AW+1:2]),
    .o_rdata (Instruction_o)
  );

endmodule
